// File: rtl/enc8to3_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_pkg
// Purpose  : Shared sizes, FSM state type and code-to-mask helper.
// Revision : 1.0
// ============================================================================
package enc_pkg;

    localparam int N      = 8;
    localparam int CODE_W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [N-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc8to3_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : enc8to3_seq_if
// Purpose  : Code/valid/ready handshake between the encoder and its consumer.
// Revision : 1.0
// ============================================================================
interface enc8to3_seq_if;
    import enc_pkg::*;

    logic [CODE_W-1:0] code;
    logic              valid;
    logic              ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);

endinterface : enc8to3_seq_if
`default_nettype wire

// File: rtl/enc8to3_seq_pri.sv
`default_nettype none
// ============================================================================
// Module   : pri_enc8to3
// Purpose  : Combinational highest-set-bit encoder with an any-set flag.
// Revision : 1.0
// ============================================================================
module pri_enc8to3
    import enc_pkg::*;
(
    input  wire logic [N-1:0]      in_mask,
    output      logic [CODE_W-1:0] code,
    output      logic              any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        code = '0;
        any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_mask[i]) begin
                code = CODE_W'(i);
                any  = 1'b1;
            end
        end
    end

endmodule : pri_enc8to3
`default_nettype wire

// File: rtl/enc8to3_seq.sv
`default_nettype none
// ============================================================================
// Module   : enc8to3_seq
// Purpose  : Captures request events into a pending mask and drains them as
//            3-bit codes, highest index first, over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module enc8to3_seq
    import enc_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          en,
    input  wire logic [N-1:0]  req,
    enc8to3_seq_if.master      bus,
    output      logic [N-1:0]  pending,
    output      logic          ovf
);

    state_t            r_state;
    logic [N-1:0]      r_pending;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_ovf;

    logic              w_hs;
    logic [N-1:0]      w_served;
    logic [N-1:0]      w_avail;
    logic [N-1:0]      w_events;
    logic [N-1:0]      w_pri_in;
    logic [CODE_W-1:0] w_pri_code;
    logic              w_pri_any;

    assign w_hs     = r_valid & bus.ready;
    assign w_served = w_hs ? onehot(r_code) : '0;
    assign w_avail  = r_pending & ~w_served;
    assign w_events = en ? req : '0;
    assign w_pri_in = (r_state == OFFER) ? w_avail : r_pending;

    pri_enc8to3 u_pri (
        .in_mask (w_pri_in),
        .code    (w_pri_code),
        .any     (w_pri_any)
    );

    // New events are OR-ed in after the clear, so a re-arriving served bit stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_avail | w_events;
            r_ovf     <= |(w_events & w_avail);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pri_any) begin
                        r_state <= OFFER;
                        r_code  <= w_pri_code;
                        r_valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (w_hs) begin
                        if (w_pri_any) begin
                            r_code <= w_pri_code;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.code  = r_code;
    assign bus.valid = r_valid;
    assign pending   = r_pending;
    assign ovf       = r_ovf;

endmodule : enc8to3_seq
`default_nettype wire

// File: tb/tb_enc8to3_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc8to3_seq
// Purpose  : Directed self-checking bench for enc8to3_seq.
// Revision : 1.0
// ============================================================================
module tb_enc8to3_seq;
    import enc_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] pending;
    logic         ovf;

    int n_pass;
    int n_total;

    enc8to3_seq_if bus_if ();

    enc8to3_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .bus     (bus_if.master),
        .pending (pending),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set afterwards are sampled on the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        req     = 8'hFF;
        bus_if.ready = 1'b0;

        // Reset holds everything clear even with all requests asserted
        step(); step(); step();
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_valid",   32'(bus_if.valid), 32'h0);
        check("rst_ovf",     32'(ovf), 32'h0);
        rst_n = 1'b1;
        req   = 8'h00;
        step();
        check("post_rst_pending", 32'(pending), 32'h00);

        // Single event, two-edge latency
        req = 8'h10; bus_if.ready = 1'b1;
        step();
        req = 8'h00;
        check("single_pending", 32'(pending), 32'h10);
        check("single_valid_early", 32'(bus_if.valid), 32'h0);
        step();
        check("single_valid", 32'(bus_if.valid), 32'h1);
        check("single_code",  32'(bus_if.code), 32'h4);
        step();
        check("single_done_valid",   32'(bus_if.valid), 32'h0);
        check("single_done_pending", 32'(pending), 32'h00);

        // Multi-hot drain 7,5,2,0 back to back
        req = 8'hA5;
        step();
        req = 8'h00;
        check("multi_pending", 32'(pending), 32'hA5);
        step();
        check("multi_v7", 32'(bus_if.valid), 32'h1);
        check("multi_c7", 32'(bus_if.code), 32'h7);
        step();
        check("multi_c5", 32'(bus_if.code), 32'h5);
        check("multi_p5", 32'(pending), 32'h25);
        step();
        check("multi_c2", 32'(bus_if.code), 32'h2);
        step();
        check("multi_c0", 32'(bus_if.code), 32'h0);
        check("multi_v0", 32'(bus_if.valid), 32'h1);
        step();
        check("multi_end_valid",   32'(bus_if.valid), 32'h0);
        check("multi_end_pending", 32'(pending), 32'h00);

        // Stall: a higher-priority arrival must not replace the held code
        bus_if.ready = 1'b0; req = 8'h04;
        step();
        req = 8'h00;
        step();
        check("stall_code_a", 32'(bus_if.code), 32'h2);
        req = 8'h80;
        step();
        req = 8'h00;
        check("stall_code_b",   32'(bus_if.code), 32'h2);
        check("stall_pending",  32'(pending), 32'h84);
        step();
        check("stall_code_c",   32'(bus_if.code), 32'h2);
        check("stall_valid",    32'(bus_if.valid), 32'h1);
        bus_if.ready = 1'b1;
        step();
        check("preempt_code7",  32'(bus_if.code), 32'h7);
        check("preempt_valid",  32'(bus_if.valid), 32'h1);
        step();
        check("preempt_end_valid", 32'(bus_if.valid), 32'h0);

        // Set wins over clear on the served bit; no overflow
        bus_if.ready = 1'b0; req = 8'h08;
        step();
        req = 8'h00;
        step();
        check("setwin_code", 32'(bus_if.code), 32'h3);
        bus_if.ready = 1'b1; req = 8'h08;
        step();
        req = 8'h00; bus_if.ready = 1'b0;
        check("setwin_pending", 32'(pending), 32'h08);
        check("setwin_ovf",     32'(ovf), 32'h0);
        step();
        check("setwin_reoffer_valid", 32'(bus_if.valid), 32'h1);
        check("setwin_reoffer_code",  32'(bus_if.code), 32'h3);

        // Overflow: repeat event on a pending, unserved bit
        req = 8'h40;
        step();
        check("ovf_first_event", 32'(ovf), 32'h0);
        check("ovf_pending",     32'(pending), 32'h48);
        step();
        req = 8'h00;
        check("ovf_pulse", 32'(ovf), 32'h1);
        check("ovf_code_held", 32'(bus_if.code), 32'h3);
        step();
        check("ovf_clear", 32'(ovf), 32'h0);
        bus_if.ready = 1'b1;
        step();
        check("ovf_drain_c6", 32'(bus_if.code), 32'h6);
        step();
        check("ovf_drain_end", 32'(bus_if.valid), 32'h0);
        check("ovf_drain_pend", 32'(pending), 32'h00);

        // Enable gating
        bus_if.ready = 1'b0; req = 8'h03;
        step();
        en = 1'b0; req = 8'hFF;
        check("en_pending_a", 32'(pending), 32'h03);
        step();
        check("en_gated_pending", 32'(pending), 32'h03);
        check("en_gated_ovf",     32'(ovf), 32'h0);
        check("en_gated_code",    32'(bus_if.code), 32'h1);
        bus_if.ready = 1'b1;
        step();
        check("en_drain_c0",   32'(bus_if.code), 32'h0);
        check("en_drain_pend", 32'(pending), 32'h01);
        step();
        check("en_drain_end",  32'(bus_if.valid), 32'h0);
        check("en_drain_zero", 32'(pending), 32'h00);
        en = 1'b1;
        step();
        req = 8'h00; bus_if.ready = 1'b0;
        check("en_resume_pending", 32'(pending), 32'hFF);
        step();
        check("en_resume_valid", 32'(bus_if.valid), 32'h1);
        check("en_resume_code",  32'(bus_if.code), 32'h7);

        // Asynchronous reset mid-offer, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",   32'(bus_if.valid), 32'h0);
        check("async_rst_pending", 32'(pending), 32'h00);
        step();
        rst_n = 1'b1;
        step();
        check("after_rst_valid", 32'(bus_if.valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_enc8to3_seq
`default_nettype wire
